// File: rtl/mips_uart_tx.sv
// rtl/mips_uart_tx.sv - memory-mapped UART transmitter with transmit FIFO
`timescale 1ns/1ps
// Purpose: a CPU stores bytes to TXDATA (BASE_ADDR). The bytes are queued in a
// FIFO and sent on txd as 8N1 frames (start, 8 data bits LSB-first, stop).
// STATUS (BASE_ADDR+4) is {21'b0, count[6:0], ovf, busy, empty, full}.
// A store to STATUS with bit 3 set clears the sticky overflow flag.
// Optional feature: define UART_TX_PARITY_EN to add an even-parity bit
// between the data bits and the stop bit, giving an 11-bit frame.
// Ports:
//   clk          - clock, rising edge
//   reset        - synchronous active-high reset
//   memwrite     - CPU store strobe (one cycle per store)
//   memaddr      - CPU data address
//   memwritedata - CPU store data
//   memreaddata  - combinational read data (STATUS at BASE_ADDR+4, else 0)
//   sel          - combinational decode of TXDATA or STATUS address
//   txd          - registered serial output, idle high
module mips_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0010,
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] memaddr,
    input  logic [31:0] memwritedata,
    output logic [31:0] memreaddata,
    output logic        sel,
    output logic        txd
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [31:0] STAT_ADDR = BASE_ADDR + 32'd4;
    localparam logic [6:0]  DEPTH_C   = 7'(FIFO_DEPTH);
    localparam logic [15:0] CYC_LAST  = 16'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t          state_q, state_d;
    logic [15:0]     cyc_q, cyc_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            txd_q, txd_d;
    logic [6:0]      count_q, count_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            ovf_q, ovf_d;
`ifdef UART_TX_PARITY_EN
    logic            par_q, par_d;
`endif
    logic [7:0]      fifo_q [FIFO_DEPTH];

    logic            wr_data_hit, wr_stat_hit;
    logic            full, empty, push, pop, ovf_set, ovf_clr;
    logic            busy, cyc_last;
    logic [7:0]      head;
    logic [31:0]     status;
    logic            unused_wdata;

    assign wr_data_hit = memwrite && !reset && (memaddr == BASE_ADDR);
    assign wr_stat_hit = memwrite && !reset && (memaddr == STAT_ADDR);
    assign full        = (count_q == DEPTH_C);
    assign empty       = (count_q == 7'd0);
    // A store into a full FIFO is dropped even if the transmitter pops in
    // the same cycle; fullness is judged on the pre-pop count.
    assign push        = wr_data_hit && !full;
    assign ovf_set     = wr_data_hit && full;
    assign ovf_clr     = wr_stat_hit && memwritedata[3];
    assign head        = fifo_q[rd_ptr_q];
    assign cyc_last    = (cyc_q == CYC_LAST);
    assign unused_wdata = ^memwritedata[31:8];

    // FIFO bookkeeping and overflow flag
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + 7'd1;
            2'b01:   count_d = count_q - 7'd1;
            default: count_d = count_q;
        endcase
        if (ovf_clr) ovf_d = 1'b0;
        if (ovf_set) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= memwritedata[7:0];
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cyc_q    <= 16'd0;
            bit_q    <= 3'd0;
            shift_q  <= 8'd0;
            txd_q    <= 1'b1;
            count_q  <= 7'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    // Next-state logic; a byte is popped from IDLE or at the last STOP cycle
    // so consecutive frames follow with no idle gap.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^head;
`endif
                    cyc_d   = 16'd0;
                    bit_d   = 3'd0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cyc_last) begin
                    cyc_d   = 16'd0;
                    state_d = S_DATA;
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
            S_DATA: begin
                if (cyc_last) begin
                    cyc_d   = 16'd0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (cyc_last) begin
                    cyc_d   = 16'd0;
                    state_d = S_STOP;
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
`endif
            S_STOP: begin
                if (cyc_last) begin
                    cyc_d = 16'd0;
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = head;
`ifdef UART_TX_PARITY_EN
                        par_d   = ^head;
`endif
                        bit_d   = 3'd0;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic; txd is registered from the current state, so the line
    // trails the state by one cycle while every bit keeps its full length.
    always_comb begin
        txd_d = 1'b1;
        busy  = (state_q != S_IDLE);
        case (state_q)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: txd_d = par_q;
`endif
            default:  txd_d = 1'b1;
        endcase
    end

    assign status      = {21'b0, count_q, ovf_q, busy, empty, full};
    assign memreaddata = (memaddr == STAT_ADDR) ? status : 32'd0;
    assign sel         = (memaddr == BASE_ADDR) || (memaddr == STAT_ADDR);
    assign txd         = txd_q;

endmodule

// File: tb/tb_mips_uart_tx.sv
// tb/tb_mips_uart_tx.sv - scoreboard testbench for mips_uart_tx
`timescale 1ns/1ps
module tb_mips_uart_tx;

    localparam logic [31:0] BASE  = 32'hFFFF_0010;
    localparam logic [31:0] STAT  = BASE + 32'd4;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 8;
`ifdef UART_TX_PARITY_EN
    localparam int          FRAME_BITS = 11;
`else
    localparam int          FRAME_BITS = 10;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] memaddr;
    logic [31:0] memwritedata;
    logic [31:0] memreaddata;
    logic        sel;
    logic        txd;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  exp_q[$];
    int          frame_starts[$];
    logic        mon_active = 1'b0;

    mips_uart_tx #(
        .BASE_ADDR(BASE),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .memwrite(memwrite),
        .memaddr(memaddr),
        .memwritedata(memwritedata),
        .memreaddata(memreaddata),
        .sel(sel),
        .txd(txd)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference frame: start 0, data LSB-first, optional even parity, stop 1.
    function automatic logic [10:0] make_frame(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {2'b01, b, 1'b0};
`endif
    endfunction

    function automatic logic [31:0] status_word(input int cnt, input logic ovf, input logic bsy);
        return {21'b0, 7'(cnt), ovf, bsy, (cnt == 0), (cnt == DEPTH)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        memwrite     = 1'b1;
        memaddr      = addr;
        memwritedata = data;
        step();
        memwrite     = 1'b0;
        memaddr      = 32'd0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit accept);
        logic [23:0] upper;
        upper = 24'($urandom());
        if (accept) exp_q.push_back(b);
        store(BASE, {upper, b});
    endtask

    task automatic read_status(output logic [31:0] st);
        memaddr = STAT;
        @(negedge clk);
        st = memreaddata;
    endtask

    task automatic wait_idle();
        int   n;
        logic done;
        memaddr = STAT;
        n = 0;
        done = 1'b0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
            if (memreaddata[2:1] == 2'b01 && !mon_active && exp_q.size() == 0) done = 1'b1;
        end
        check("wait_idle", {31'b0, done}, 32'd1);
        step();
    endtask

    // Line monitor: decodes each frame on txd, compares every cycle against
    // the expected frame popped from the scoreboard at the start bit.
    task automatic monitor();
        int          idx;
        int          slot;
        int          cyc;
        logic [10:0] exp_f;
        logic [10:0] act_f;
        logic        glitch;
        idx = 0;
        cyc = 0;
        exp_f = '0;
        act_f = '0;
        glitch = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                mon_active = 1'b0;
            end else if (!mon_active) begin
                if (txd === 1'b0) begin
                    if (exp_q.size() == 0) exp_f = 11'h7FF;
                    else exp_f = make_frame(exp_q.pop_front());
                    act_f = '0;
                    glitch = 1'b0;
                    idx = 1;
                    mon_active = 1'b1;
                    frame_starts.push_back(cyc);
                end
            end else begin
                slot = idx / CPB;
                if (txd !== exp_f[slot]) glitch = 1'b1;
                if (idx % CPB == CPB / 2) act_f[slot] = txd;
                idx++;
                if (idx == FRAME_BITS * CPB) begin
                    check("frame", {20'b0, glitch, act_f}, {21'b0, exp_f});
                    mon_active = 1'b0;
                end
            end
        end
    endtask

    initial begin
        logic [31:0] st;
        int          n0;
        int          nb;

        reset = 1'b1;
        memwrite = 1'b0;
        memaddr = 32'd0;
        memwritedata = 32'd0;
        fork
            monitor();
        join_none
        repeat (3) step();
        reset = 1'b0;

        // Reset state and address decode
        memaddr = STAT;
        @(negedge clk);
        check("reset_status", memreaddata, status_word(0, 1'b0, 1'b0));
        check("reset_sel_stat", 32'(sel), 32'd1);
        check("reset_txd", 32'(txd), 32'd1);
        memaddr = BASE;
        @(negedge clk);
        check("rd_base_data", memreaddata, 32'd0);
        check("rd_base_sel", 32'(sel), 32'd1);
        memaddr = BASE + 32'd8;
        @(negedge clk);
        check("rd_other_data", memreaddata, 32'd0);
        check("rd_other_sel", 32'(sel), 32'd0);
        step();

        // Single byte 0xA5: start bit two edges after the accepting edge
        send_byte(8'hA5, 1'b1);
        memaddr = STAT;
        @(negedge clk);
        check("txd_edge0", 32'(txd), 32'd1);
        @(negedge clk);
        check("txd_edge1", 32'(txd), 32'd1);
        @(negedge clk);
        check("txd_edge2_start", 32'(txd), 32'd0);
        repeat (FRAME_BITS * CPB + 1 - 3) @(negedge clk);
        check("busy_last_stop", 32'(memreaddata[2]), 32'd1);
        @(negedge clk);
        check("busy_after_frame", 32'(memreaddata[2]), 32'd0);
        wait_idle();

        // Two stores: back-to-back frames with no idle gap
        n0 = frame_starts.size();
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        wait_idle();
        check("b2b_frames", 32'(frame_starts.size() - n0), 32'd2);
        if (frame_starts.size() - n0 >= 2)
            check("b2b_gap", 32'(frame_starts[n0 + 1] - frame_starts[n0]), 32'(FRAME_BITS * CPB));

        // Overflow: one byte in flight, 8 fill the FIFO, the 9th is dropped
        send_byte(8'h11, 1'b1);
        repeat (3) step();
        for (int i = 0; i < DEPTH; i++) send_byte(8'(8'h20 + i), 1'b1);
        send_byte(8'h99, 1'b0);
        read_status(st);
        check("ovf_status", st, status_word(DEPTH, 1'b1, 1'b1));
        store(STAT, 32'h0000_0007);
        read_status(st);
        check("ovf_kept_bit3_0", st, status_word(DEPTH, 1'b1, 1'b1));
        store(BASE + 32'd8, $urandom());
        read_status(st);
        check("other_addr_no_effect", st, status_word(DEPTH, 1'b1, 1'b1));
        store(STAT, 32'h0000_0008);
        read_status(st);
        check("ovf_cleared", st, status_word(DEPTH, 1'b0, 1'b1));
        wait_idle();

        // Random bursts that never exceed the FIFO
        for (int it = 0; it < 6; it++) begin
            nb = $urandom_range(1, DEPTH);
            for (int k = 0; k < nb; k++) begin
                send_byte(8'($urandom()), 1'b1);
                repeat ($urandom_range(0, 3)) step();
            end
            wait_idle();
            read_status(st);
            check("random_idle_status", st, status_word(0, 1'b0, 1'b0));
            step();
        end

        // Parity-relevant bytes (odd and even number of ones)
        send_byte(8'h07, 1'b1);
        wait_idle();
        send_byte(8'h03, 1'b1);
        wait_idle();

        // Reset mid-DATA with three bytes queued
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b1);
        send_byte(8'h77, 1'b1);
        send_byte(8'h88, 1'b1);
        repeat (12) step();
        reset = 1'b1;
        exp_q.delete();
        memaddr = STAT;
        step();
        @(negedge clk);
        check("midreset_txd", 32'(txd), 32'd1);
        check("midreset_status", memreaddata, status_word(0, 1'b0, 1'b0));
        memwrite = 1'b1;
        memaddr = BASE;
        memwritedata = 32'h0000_0042;
        step();
        memwrite = 1'b0;
        reset = 1'b0;
        memaddr = STAT;
        n0 = frame_starts.size();
        repeat (100) step();
        @(negedge clk);
        check("post_reset_status", memreaddata, status_word(0, 1'b0, 1'b0));
        check("post_reset_no_frames", 32'(frame_starts.size() - n0), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mips_uart_tx.md
MIPS_UART_TX -- requirements
Module: mips_uart_tx

Interface
REQ-001 The module SHALL have parameter BASE_ADDR, default 32'hFFFF_0010, giving the word address of the TXDATA register; STATUS is at BASE_ADDR+4.
REQ-002 The module SHALL have parameter CLKS_PER_BIT, default 434, giving the clock cycles per serial bit; legal range is 2..65535.
REQ-003 The module SHALL have parameter FIFO_DEPTH, default 8, giving the transmit FIFO entries; it SHALL be a power of 2 in the range 2..64.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have port memwrite, input, 1 bit: CPU store strobe, valid for one cycle per store.
REQ-007 The module SHALL have port memaddr, input, 32 bits: CPU data address.
REQ-008 The module SHALL have port memwritedata, input, 32 bits: CPU store data.
REQ-009 The module SHALL have port memreaddata, output, 32 bits: combinational read data; equals STATUS when memaddr==BASE_ADDR+4, else 0.
REQ-010 The module SHALL have port sel, output, 1 bit: combinational; 1 when memaddr equals BASE_ADDR or BASE_ADDR+4.
REQ-011 The module SHALL have port txd, output, 1 bit: registered serial line, idle high.

Function
REQ-012 A store to BASE_ADDR with count<FIFO_DEPTH SHALL push memwritedata[7:0] into the FIFO; memwritedata[31:8] is ignored.
REQ-013 A store to BASE_ADDR while count==FIFO_DEPTH SHALL be dropped and SHALL set sticky bit OVF, even if a pop occurs in the same cycle.
REQ-014 STATUS SHALL be {21'b0, count[6:0], OVF, busy, empty, full}, with count at bits [10:4].
REQ-015 A store to BASE_ADDR+4 with memwritedata[3]==1 SHALL clear OVF; if an overflow occurs in the same cycle, set SHALL win.
REQ-016 A simultaneous accepted push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-017 The FSM SHALL have states IDLE, START, DATA, [PARITY], and STOP; busy SHALL be 1 in every state except IDLE.
REQ-018 In IDLE with empty==0, the FSM SHALL pop the head byte into the shift register and enter START on the next edge.
REQ-019 txd SHALL be low for START, carry bits LSB-first for DATA (8 bits), be high for STOP, and be high in IDLE; each bit SHALL last exactly CLKS_PER_BIT cycles.
REQ-020 At the end of STOP, the FSM SHALL pop and re-enter START immediately when the FIFO is non-empty, giving no idle gap between frames; otherwise it SHALL enter IDLE.
REQ-021 With an empty FIFO and FSM in IDLE, txd SHALL fall exactly 2 rising edges after the edge that accepts the write.
REQ-022 Stores to any other address SHALL have no effect; memwrite==0 SHALL never modify state.

Reset
REQ-023 When reset is asserted, on the next edge the FSM SHALL go to IDLE, txd to 1, the FIFO to empty (count 0), OVF to 0, and the bit and cycle counters to 0, including when reset occurs mid-frame.
REQ-024 While reset is asserted, stores SHALL be ignored.

Configuration
REQ-025 With macro UART_TX_PARITY_EN defined, the FSM SHALL insert a PARITY state after DATA, driving even parity (the XOR of the 8 data bits) for CLKS_PER_BIT cycles, giving a frame of 11 bits.
REQ-026 Without UART_TX_PARITY_EN, the PARITY state SHALL not exist and the frame SHALL be 10 bits.

Verification
REQ-027 The bench SHALL cover this scenario: CLKS_PER_BIT=4, store 0xA5 to BASE_ADDR -> txd low 2 edges later, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high; busy=0 after 40 cycles.
REQ-028 The bench SHALL cover this scenario: 9 back-to-back stores with FIFO_DEPTH=8 and the FSM held busy -> the 9th byte is dropped, STATUS OVF=1 and full=1; a store of 0x8 to BASE_ADDR+4 -> OVF=0.
REQ-029 The bench SHALL cover this scenario: stores 0x01, 0x02 -> two frames with no idle cycle between the STOP of frame 1 and the START of frame 2.
REQ-030 The bench SHALL cover this scenario: reset asserted mid-DATA with 3 bytes queued -> the next edge gives txd=1, count=0, busy=0, and no further frames.
REQ-031 The bench SHALL cover this scenario: with UART_TX_PARITY_EN defined, a store of 0x07 -> parity bit 1, frame 11 bits; a store of 0x03 -> parity bit 0.
REQ-032 The bench SHALL cover this scenario: a read at BASE_ADDR+4 with an empty FIFO -> memreaddata=32'h2 and sel=1; a read at BASE_ADDR+8 -> memreaddata=0 and sel=0.
